writeback_stage: RTL and testbench

//  MEM/WB pipeline register plus writeback logic for the RISC-V core.

---
 rtl/writeback_stage_pkg.sv | 18 +
 rtl/writeback_stage_load_extend.sv | 30 +++
 rtl/writeback_stage.sv | 128 ++++++++++++
 tb/tb_writeback_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared writeback-select and load funct3 encodings.
// Decode and MEM use the same encodings.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WbSelAlu  = 2'b00,
        WbSelLoad = 2'b01,
        WbSelPc4  = 2'b10,
        WbSelImm  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Selects the addressed byte/half of a loaded word and sign/zero extends it.
module writeback_stage_load_extend
    import writeback_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{addr, 3'b000} +: 8];
        // addr[0] is ignored for halfword loads
        half_v = addr[1] ? word[31:16] : word[15:0];
        unique case (funct3)
            LOAD_LB:  result = {{(XLEN - 8){byte_v[7]}}, byte_v};
            LOAD_LBU: result = {{(XLEN - 8){1'b0}}, byte_v};
            LOAD_LH:  result = {{(XLEN - 16){half_v[15]}}, half_v};
            LOAD_LHU: result = {{(XLEN - 16){1'b0}}, half_v};
            LOAD_LW:  result = word;
            default:  result = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback mux, register-file write port,
// forwarding bus, retire trace and retired-instruction counter.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic [XLEN-1:0]  mem_pc,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_we,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_imm,
    input  logic [XLEN-1:0]  mem_load_data,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wd,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic             wb_have_inst,
    output logic [XLEN-1:0]  wb_pc,
    output logic             wb_ena,
    output logic [4:0]       wb_reg,
    output logic [XLEN-1:0]  wb_value,
    output logic [CNT_W-1:0] instret
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            reg_we;
        logic [1:0]      wb_sel;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] load_data;
    } wb_reg_t;

    wb_reg_t          wb_q, wb_d;
    logic             retired_q, retired_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [XLEN-1:0]  load_ext;
    logic [XLEN-1:0]  wd;
    logic             we;
    logic             have_inst;

    writeback_stage_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .funct3 (wb_q.funct3),
        .addr   (wb_q.alu_result[1:0]),
        .word   (wb_q.load_data),
        .result (load_ext)
    );

    always_comb begin
        wb_d      = wb_q;
        retired_d = retired_q;
        if (flush) begin
            wb_d      = '0;
            retired_d = 1'b0;
        end else if (stall) begin
            // A held instruction has already announced itself after its first cycle
            retired_d = retired_q | wb_q.valid;
        end else begin
            wb_d.valid      = mem_valid;
            wb_d.pc         = mem_pc;
            wb_d.rd         = mem_rd;
            wb_d.reg_we     = mem_reg_we;
            wb_d.wb_sel     = mem_wb_sel;
            wb_d.funct3     = mem_funct3;
            wb_d.alu_result = mem_alu_result;
            wb_d.imm        = mem_imm;
            wb_d.load_data  = mem_load_data;
            retired_d       = 1'b0;
        end
        // Counts the current pulse even when a flush lands on the same edge
        instret_d = have_inst ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q      <= '0;
            retired_q <= 1'b0;
            instret_q <= '0;
        end else begin
            wb_q      <= wb_d;
            retired_q <= retired_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        unique case (wb_sel_e'(wb_q.wb_sel))
            WbSelAlu:  wd = wb_q.alu_result;
            WbSelLoad: wd = load_ext;
            WbSelPc4:  wd = wb_q.pc + XLEN'(4);
            WbSelImm:  wd = wb_q.imm;
            default:   wd = wb_q.alu_result;
        endcase
    end

    assign we        = wb_q.valid & wb_q.reg_we & (wb_q.rd != 5'd0);
    assign have_inst = wb_q.valid & ~retired_q;

    assign rf_we        = we;
    assign rf_rd        = wb_q.rd;
    assign rf_wd        = wd;
    assign fwd_valid    = we;
    assign fwd_rd       = wb_q.rd;
    assign fwd_data     = wd;
    assign wb_have_inst = have_inst;
    assign wb_pc        = wb_q.pc;
    assign wb_ena       = we & have_inst;
    assign wb_reg       = wb_q.rd;
    assign wb_value     = wd;
    assign instret      = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed-vector bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_reg_we;
    logic [31:0] mem_pc, mem_alu_result, mem_imm, mem_load_data;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic        rf_we, fwd_valid, wb_have_inst, wb_ena;
    logic [4:0]  rf_rd, fwd_rd, wb_reg;
    logic [31:0] rf_wd, fwd_data, wb_pc, wb_value;
    logic [63:0] instret;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    writeback_stage #(
        .XLEN  (32),
        .CNT_W (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_rd         (mem_rd),
        .mem_reg_we     (mem_reg_we),
        .mem_wb_sel     (mem_wb_sel),
        .mem_funct3     (mem_funct3),
        .mem_alu_result (mem_alu_result),
        .mem_imm        (mem_imm),
        .mem_load_data  (mem_load_data),
        .rf_we          (rf_we),
        .rf_rd          (rf_rd),
        .rf_wd          (rf_wd),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data),
        .wb_have_inst   (wb_have_inst),
        .wb_pc          (wb_pc),
        .wb_ena         (wb_ena),
        .wb_reg         (wb_reg),
        .wb_value       (wb_value),
        .instret        (instret)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] imm,
                         input logic [31:0] ld);
        mem_valid      = 1'b1;
        mem_reg_we     = 1'b1;
        mem_pc         = pc;
        mem_rd         = rd;
        mem_wb_sel     = sel;
        mem_funct3     = f3;
        mem_alu_result = alu;
        mem_imm        = imm;
        mem_load_data  = ld;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        issue(32'h40, 5'd5, 2'b00, 3'b000, 32'h1111, 32'h0, 32'h0);

        // Reset held two edges with a valid instruction on the MEM side
        step();
        step();
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_have", 64'(wb_have_inst), 64'd0);
        check("rst_instret", instret, 64'd0);
        check("rst_wd", 64'(rf_wd), 64'd0);
        rst = 1'b0;

        // Load extension
        issue(32'h100, 5'd5, 2'b01, 3'b000, 32'h203, 32'h0, 32'h80FF_1234);
        step();
        check("lb_wd", 64'(rf_wd), 64'hFFFF_FF80);
        check("lb_we", 64'(rf_we), 64'd1);
        check("lb_have", 64'(wb_have_inst), 64'd1);
        check("lb_fwd", 64'(fwd_data), 64'hFFFF_FF80);
        check("lb_cnt", instret, 64'd0);
        issue(32'h104, 5'd6, 2'b01, 3'b100, 32'h203, 32'h0, 32'h80FF_1234);
        step();
        check("lbu_wd", 64'(rf_wd), 64'h0000_0080);
        check("lbu_cnt", instret, 64'd1);
        issue(32'h108, 5'd7, 2'b01, 3'b001, 32'h202, 32'h0, 32'h8001_7FFF);
        step();
        check("lh_wd", 64'(rf_wd), 64'hFFFF_8001);
        issue(32'h10C, 5'd8, 2'b01, 3'b101, 32'h200, 32'h0, 32'h8001_7FFF);
        step();
        check("lhu_wd", 64'(rf_wd), 64'h0000_7FFF);
        issue(32'h110, 5'd9, 2'b01, 3'b010, 32'h203, 32'h0, 32'hA5A5_0F0F);
        step();
        check("lw_wd", 64'(rf_wd), 64'hA5A5_0F0F);
        check("lw_cnt", instret, 64'd4);

        // ALU write to x0
        issue(32'h114, 5'd0, 2'b00, 3'b000, 32'hDEAD, 32'h0, 32'h0);
        step();
        check("x0_we", 64'(rf_we), 64'd0);
        check("x0_ena", 64'(wb_ena), 64'd0);
        check("x0_have", 64'(wb_have_inst), 64'd1);
        check("x0_cnt", instret, 64'd5);

        // JAL held by stall
        issue(32'h1000, 5'd1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        check("jal_wd", 64'(rf_wd), 64'h1004);
        check("jal_ena", 64'(wb_ena), 64'd1);
        check("jal_cnt", instret, 64'd6);
        stall = 1'b1;
        issue(32'h2000, 5'd2, 2'b00, 3'b000, 32'h5555, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_wd", 64'(rf_wd), 64'h1004);
            check("stall_we", 64'(rf_we), 64'd1);
            check("stall_have", 64'(wb_have_inst), 64'd0);
            check("stall_ena", 64'(wb_ena), 64'd0);
            check("stall_cnt", instret, 64'd7);
        end
        stall = 1'b0;

        // PC+4 wrap, then LUI immediate
        issue(32'hFFFF_FFFC, 5'd3, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0);
        step();
        check("pc4_wrap", 64'(rf_wd), 64'd0);
        issue(32'h2004, 5'd4, 2'b11, 3'b000, 32'h0, 32'h1234_5000, 32'h0);
        step();
        check("imm_wd", 64'(rf_wd), 64'h1234_5000);
        check("imm_rd", 64'(rf_rd), 64'd4);
        check("imm_cnt", instret, 64'd8);

        // Flush beats stall; the pulse on that edge still counts
        stall = 1'b1; flush = 1'b1;
        step();
        check("flush_we", 64'(rf_we), 64'd0);
        check("flush_have", 64'(wb_have_inst), 64'd0);
        check("flush_cnt", instret, 64'd9);
        stall = 1'b0; flush = 1'b0;

        // Reset then 10 back-to-back ALU ops
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_cnt", instret, 64'd0);
        for (int i = 0; i < 10; i++) begin
            issue(32'h300 + 32'(4 * i), 5'(i + 1), 2'b00, 3'b000, 32'(i * 3 + 7), 32'h0, 32'h0);
            step();
            check("seq_pc", 64'(wb_pc), 64'(32'h300 + 32'(4 * i)));
            check("seq_wd", 64'(wb_value), 64'(i * 3 + 7));
            check("seq_have", 64'(wb_have_inst), 64'd1);
        end
        mem_valid = 1'b0;
        step();
        check("seq_cnt", instret, 64'd10);
        check("idle_have", 64'(wb_have_inst), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
